dtc_result_window: RTL and testbench



---
 rtl/dtc_result_window_if.sv | 44 ++++
 rtl/dtc_result_window.sv | 114 +++++++++++
 tb/tb_dtc_result_window.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dtc_result_window_if.sv
// dtc_result_window_if
//   Handshake bundle for the decision-tree result window.
//   Input side : in_valid / in_ready / in_class, plus flush (early window close).
//   Output side: out_valid / out_ready / out_class / out_count / out_len,
//                and out_tie only when DTC_TIE_FLAG_EN is defined.
//   Modports   : slave  - the window block (accepts samples, presents results)
//                master - the environment (produces samples, consumes results)
//
//   Handshake semantics (both channels): a transfer happens on a rising clk
//   edge where valid && ready are both 1. A producer holding valid keeps its
//   data stable until the transfer; ready may be asserted without valid.
interface dtc_result_window_if #(
  parameter int WIN = 16,
  localparam int CNT_W = $clog2(WIN + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic             in_class;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_class;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_len;
`ifdef DTC_TIE_FLAG_EN
  logic             out_tie;
`endif

  modport slave (
    input  in_valid, in_class, flush, out_ready,
    output in_ready, out_valid, out_class, out_count, out_len
`ifdef DTC_TIE_FLAG_EN
    , output out_tie
`endif
  );

  modport master (
    output in_valid, in_class, flush, out_ready,
    input  in_ready, out_valid, out_class, out_count, out_len
`ifdef DTC_TIE_FLAG_EN
    , input out_tie
`endif
  );
endinterface

// File: rtl/dtc_result_window.sv
// dtc_result_window
//   Accumulates 1-bit classifier predictions over a window of WIN samples and
//   presents a registered majority decision, ones-count and window length.
//   A window closes when the WIN-th sample is accepted, or early on flush when
//   it holds at least one sample. The result is held until the consumer takes
//   it; no samples are accepted meanwhile (one bubble per window).
//
//   Ports:
//     clk       - rising-edge clock
//     rst_n     - synchronous active-low reset
//     bus       - dtc_result_window_if.slave (sample input, flush, result output)
//     dbg_state - current FSM state (0 = ACCUM, 1 = HOLD)
//
//   Optional feature macro: DTC_TIE_FLAG_EN adds out_tie (2*ones == samples).
//   Ties always resolve to out_class = 0.
module dtc_result_window #(
  parameter int WIN = 16,
  localparam int CNT_W = $clog2(WIN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dtc_result_window_if.slave      bus,
  output logic                    dbg_state
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_cnt, ones_cnt;
  logic [CNT_W-1:0] n_nxt, ones_nxt;
  logic             accept, close;
  logic             majority;
  logic             r_class;
  logic [CNT_W-1:0] r_count, r_len;
`ifdef DTC_TIE_FLAG_EN
  logic             tie;
  logic             r_tie;
`endif

  // Counts including the sample taken this cycle; never exceed WIN because
  // reaching WIN closes the window and clears the counters.
  assign n_nxt    = n_cnt + CNT_W'(accept);
  assign ones_nxt = ones_cnt + CNT_W'(accept && bus.in_class);

  // Compare 2*ones against n one bit wider so the doubling cannot overflow.
  assign majority = ({ones_nxt, 1'b0} > {1'b0, n_nxt});
`ifdef DTC_TIE_FLAG_EN
  assign tie      = ({ones_nxt, 1'b0} == {1'b0, n_nxt});
`endif

  // FSM next state and handshake outputs.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    close        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACCUM: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        // A flush on an empty window (nothing held, nothing arriving) is dropped.
        close = (accept && (n_nxt == CNT_W'(WIN))) ||
                (bus.flush && (n_nxt != '0));
        if (close) state_nxt = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Counters and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_cnt    <= '0;
      ones_cnt <= '0;
      r_class  <= 1'b0;
      r_count  <= '0;
      r_len    <= '0;
`ifdef DTC_TIE_FLAG_EN
      r_tie    <= 1'b0;
`endif
    end else if (close) begin
      n_cnt    <= '0;
      ones_cnt <= '0;
      r_class  <= majority;
      r_count  <= ones_nxt;
      r_len    <= n_nxt;
`ifdef DTC_TIE_FLAG_EN
      r_tie    <= tie;
`endif
    end else if (accept) begin
      n_cnt    <= n_nxt;
      ones_cnt <= ones_nxt;
    end
  end

  assign bus.out_class = r_class;
  assign bus.out_count = r_count;
  assign bus.out_len   = r_len;
`ifdef DTC_TIE_FLAG_EN
  assign bus.out_tie   = r_tie;
`endif
  assign dbg_state     = state;

endmodule

// File: tb/tb_dtc_result_window.sv
// tb_dtc_result_window
//   Directed scenarios for WIN=4 plus a randomized run scored against a
//   sample-queue model of the window behaviour.
module tb_dtc_result_window;
  localparam int WIN   = 4;
  localparam int CNT_W = $clog2(WIN + 1);
  localparam int W     = 2 * CNT_W + 2;   // {tie, class, count, len}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  always #5 clk = ~clk;

  dtc_result_window_if #(.WIN(WIN)) bus ();
  dtc_result_window #(.WIN(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  bit             m_hold;
  bit             m_win[$];
  logic [W-1:0]   exp_q[$];

  // Applies one clock edge of spec behaviour using the inputs present at it.
  task automatic model_edge(input logic v, input logic c, input logic f, input logic r);
    int ones;
    int len;
    if (!rst_n) begin
      m_hold = 1'b0;
      m_win.delete();
      exp_q.delete();
    end else if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else begin
      if (v) m_win.push_back(c);
      if ((v && m_win.size() == WIN) || (f && m_win.size() > 0)) begin
        ones = 0;
        foreach (m_win[i]) ones += m_win[i];
        len = m_win.size();
        exp_q.push_back({(2 * ones == len), (2 * ones > len), CNT_W'(ones), CNT_W'(len)});
        m_win.delete();
        m_hold = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive(input logic v, input logic c, input logic f, input logic r);
    bus.in_valid  = v;
    bus.in_class  = c;
    bus.flush     = f;
    bus.out_ready = r;
    @(posedge clk);
    model_edge(v, c, f, r);
    @(negedge clk);
  endtask

  task automatic feed4(input logic [3:0] bits, input logic r);
    for (int i = 3; i >= 0; i--) drive(1'b1, bits[i], 1'b0, r);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_class !== 1'b0) $display("FAIL reset_out_class got=%b exp=0", bus.out_class); else n_pass++;
    n_checks++; if (bus.out_count !== '0) $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); else n_pass++;
    n_checks++; if (bus.out_len !== '0) $display("FAIL reset_out_len got=%0d exp=0", bus.out_len); else n_pass++;
    n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state got=%b exp=0", dbg_state); else n_pass++;
`ifdef DTC_TIE_FLAG_EN
    n_checks++; if (bus.out_tie !== 1'b0) $display("FAIL reset_out_tie got=%b exp=0", bus.out_tie); else n_pass++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic_window();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid); else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic_latency got=%b exp=1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL basic_hold_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_count !== CNT_W'(3)) $display("FAIL basic_count got=%0d exp=3", bus.out_count); else n_pass++;
    n_checks++; if (bus.out_len !== CNT_W'(4)) $display("FAIL basic_len got=%0d exp=4", bus.out_len); else n_pass++;
    n_checks++; if (bus.out_class !== 1'b1) $display("FAIL basic_class got=%b exp=1", bus.out_class); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL basic_ready_after got=%b exp=1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_valid_after got=%b exp=0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_tie();
    feed4(4'b1010, 1'b1);
    n_checks++; if (bus.out_class !== 1'b0) $display("FAIL tie_class got=%b exp=0", bus.out_class); else n_pass++;
    n_checks++; if (bus.out_count !== CNT_W'(2)) $display("FAIL tie_count got=%0d exp=2", bus.out_count); else n_pass++;
`ifdef DTC_TIE_FLAG_EN
    n_checks++; if (bus.out_tie !== 1'b1) $display("FAIL tie_flag got=%b exp=1", bus.out_tie); else n_pass++;
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_valid got=%b exp=1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_len !== CNT_W'(2)) $display("FAIL flush_len got=%0d exp=2", bus.out_len); else n_pass++;
    n_checks++; if (bus.out_count !== CNT_W'(2)) $display("FAIL flush_count got=%0d exp=2", bus.out_count); else n_pass++;
    n_checks++; if (bus.out_class !== 1'b1) $display("FAIL flush_class got=%b exp=1", bus.out_class); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    // Following window must start from zero.
    feed4(4'b0100, 1'b1);
    n_checks++; if (bus.out_count !== CNT_W'(1)) $display("FAIL flush_next_count got=%0d exp=1", bus.out_count); else n_pass++;
    n_checks++; if (bus.out_len !== CNT_W'(4)) $display("FAIL flush_next_len got=%0d exp=4", bus.out_len); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    feed4(4'b1000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_count !== CNT_W'(1) ||
          bus.out_len !== CNT_W'(4) || bus.out_class !== 1'b0)
        $display("FAIL bp_hold cyc=%0d got v=%b r=%b cnt=%0d len=%0d cls=%b exp v=1 r=0 cnt=1 len=4 cls=0",
                 i, bus.out_valid, bus.in_ready, bus.out_count, bus.out_len, bus.out_class);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); else n_pass++;
    // Any sample swallowed during HOLD would show up as ones here.
    feed4(4'b0000, 1'b1);
    n_checks++; if (bus.out_count !== CNT_W'(0)) $display("FAIL bp_no_accept_count got=%0d exp=0", bus.out_count); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); else n_pass++;
    feed4(4'b0000, 1'b1);
    n_checks++; if (bus.out_count !== CNT_W'(0)) $display("FAIL rstmid_count got=%0d exp=0", bus.out_count); else n_pass++;
    n_checks++; if (bus.out_len !== CNT_W'(4)) $display("FAIL rstmid_len got=%0d exp=4", bus.out_len); else n_pass++;
    n_checks++; if (bus.out_class !== 1'b0) $display("FAIL rstmid_class got=%b exp=0", bus.out_class); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush_boundaries();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);   // flush together with the 4th sample
    n_checks++; if (bus.out_count !== CNT_W'(2)) $display("FAIL flushlast_count got=%0d exp=2", bus.out_count); else n_pass++;
    n_checks++; if (bus.out_len !== CNT_W'(4)) $display("FAIL flushlast_len got=%0d exp=4", bus.out_len); else n_pass++;
    drive(1'b0, 1'b0, 1'b1, 1'b1);   // handshake; flush in HOLD ignored
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1); // flush on an empty window
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL empty_flush cyc=%0d got=%b exp=0", i, bus.out_valid); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic v, c, f, r;
    logic [W-1:0] e;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 2) != 0);
      n_checks++;
      if (bus.in_ready !== !m_hold || bus.out_valid !== m_hold)
        $display("FAIL rand_hs cyc=%0d got r=%b v=%b exp r=%b v=%b", i, bus.in_ready, bus.out_valid, !m_hold, m_hold);
      else n_pass++;
      if (m_hold) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_scoreboard cyc=%0d got empty exp one entry", i);
        else begin
          e = exp_q[0];
          if (bus.out_class !== e[2*CNT_W] || bus.out_count !== e[2*CNT_W-1:CNT_W] || bus.out_len !== e[CNT_W-1:0]
`ifdef DTC_TIE_FLAG_EN
              || bus.out_tie !== e[2*CNT_W+1]
`endif
             )
            $display("FAIL rand_result cyc=%0d got cls=%b cnt=%0d len=%0d exp cls=%b cnt=%0d len=%0d", i,
                     bus.out_class, bus.out_count, bus.out_len, e[2*CNT_W], e[2*CNT_W-1:CNT_W], e[CNT_W-1:0]);
          else n_pass++;
          if (r) void'(exp_q.pop_front());
        end
      end
      drive(v, c, f, r);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid = 1'b0; bus.in_class = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    m_hold = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_window();
    test_tie();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_flush_boundaries();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
